// File: rtl/lc_ctrl_pkg.sv
// Shared types for the life cycle transfer arbiter: escalation encoding,
// arbiter state encoding, requester indices and token type.
package lc_ctrl_pkg;

  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;

  // Pairwise Hamming distance >= 3 so a single upset never lands on a legal state.
  typedef enum logic [4:0] {
    XferFree   = 5'b10011,
    XferOwned  = 5'b01101,
    XferReq    = 5'b00110,
    XferLocked = 5'b11000
  } lc_xfer_st_e;

  typedef enum logic {
    XferSw  = 1'b0,
    XferTap = 1'b1
  } lc_xfer_req_e;

  localparam int unsigned LcTokenWidth = 128;
  typedef logic [LcTokenWidth-1:0] lc_token_t;

  function automatic logic [1:0] claim_winner(input logic [1:0] claim, input logic tap_prio);
    if (claim == 2'b11) return tap_prio ? 2'b10 : 2'b01;
    return claim;
  endfunction

endpackage

// File: rtl/lc_ctrl_xfer_timer.sv
// Saturating cycle counter with synchronous clear; expired flags the last
// cycle of the allowed window.
module lc_ctrl_xfer_timer #(
  parameter int unsigned Cycles = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Cycles);
  localparam logic [CntW-1:0] CntMax = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CntMax)) begin
      cnt <= cnt + CntW'(1);
    end
  end

  assign expired = (cnt == CntMax);

endmodule

// File: rtl/lc_ctrl_xfer_arb.sv
// Claim/release mutex between SW and TAP for the life cycle transition
// interface, with a single timed request/ack handshake and escalation lockdown.
module lc_ctrl_xfer_arb
  import lc_ctrl_pkg::*;
#(
  parameter int unsigned TargetWidth   = 5,
  parameter int unsigned TokenWidth    = 128,
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic        TapPriority   = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [1:0]                  claim_i,
  input  logic [1:0]                  release_i,
  input  logic [1:0]                  start_i,
  input  logic [1:0][TargetWidth-1:0] tgt_i,
  input  logic [1:0][TokenWidth-1:0]  token_i,
  input  lc_tx_t                      lc_escalate_en_i,
  output logic [1:0]                  owner_o,
  output logic                        trans_req_o,
  output logic [TargetWidth-1:0]      trans_tgt_o,
  output logic [TokenWidth-1:0]       trans_token_o,
  input  logic                        trans_ack_i,
  input  logic                        trans_err_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        timeout_o,
  output logic                        locked_o
);

  lc_xfer_st_e state;
  logic esc, lock_st, expired, own_idx, own_rel, own_start;

  assign esc       = (lc_escalate_en_i != Off);
  // Locked and any illegal encoding both take the lockdown path every cycle.
  assign lock_st   = !(state inside {XferFree, XferOwned, XferReq});
  assign own_idx   = owner_o[XferTap];
  assign own_rel   = release_i[own_idx];
  assign own_start = start_i[own_idx];

  lc_ctrl_xfer_timer #(
    .Cycles(TimeoutCycles)
  ) u_timer (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .clr     (state != XferReq),
    .en      (state == XferReq),
    .expired (expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= XferFree;
      owner_o       <= '0;
      trans_req_o   <= 1'b0;
      trans_tgt_o   <= '0;
      trans_token_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      timeout_o     <= 1'b0;
      locked_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (esc || lock_st) begin
        state         <= XferLocked;
        owner_o       <= '0;
        trans_req_o   <= 1'b0;
        trans_tgt_o   <= '0;
        trans_token_o <= '0;
        busy_o        <= 1'b0;
        locked_o      <= 1'b1;
      end else begin
        case (state)
          XferFree: begin
            if (claim_i != 2'b00) begin
              owner_o <= claim_winner(claim_i, TapPriority);
              state   <= XferOwned;
            end
          end
          XferOwned: begin
            if (own_rel) begin
              state         <= XferFree;
              owner_o       <= '0;
              trans_tgt_o   <= '0;
              trans_token_o <= '0;
              err_o         <= 1'b0;
              timeout_o     <= 1'b0;
            end else if (own_start) begin
              state         <= XferReq;
              trans_tgt_o   <= tgt_i[own_idx];
              trans_token_o <= token_i[own_idx];
              trans_req_o   <= 1'b1;
              busy_o        <= 1'b1;
              err_o         <= 1'b0;
              timeout_o     <= 1'b0;
            end
          end
          XferReq: begin
            if (trans_ack_i) begin
              state       <= XferOwned;
              trans_req_o <= 1'b0;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              err_o       <= err_o | trans_err_i;
            end else if (expired) begin
              state       <= XferOwned;
              trans_req_o <= 1'b0;
              busy_o      <= 1'b0;
              err_o       <= 1'b1;
              timeout_o   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lc_ctrl_xfer_arb.sv
// Scoreboard bench for lc_ctrl_xfer_arb: each driven cycle queues the expected
// outputs, which are popped and compared after the clock edge.
module tb_lc_ctrl_xfer_arb;
  import lc_ctrl_pkg::*;

  localparam int TW = 5;
  localparam int KW = 128;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_ni;
  logic [1:0]          claim_i, release_i, start_i;
  logic [1:0][TW-1:0]  tgt_i;
  logic [1:0][KW-1:0]  token_i;
  lc_tx_t              esc;
  logic                trans_ack_i, trans_err_i;

  logic [1:0]          owner_o;
  logic                trans_req_o, busy_o, done_o, err_o, timeout_o, locked_o;
  logic [TW-1:0]       trans_tgt_o;
  logic [KW-1:0]       trans_token_o;

  logic [1:0]          owner0;
  logic                req0, busy0, done0, err0, tmo0, lck0;
  logic [TW-1:0]       tgt0;
  logic [KW-1:0]       tok0;

  lc_ctrl_xfer_arb #(.TargetWidth(TW), .TokenWidth(KW), .TimeoutCycles(TO), .TapPriority(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .claim_i(claim_i), .release_i(release_i), .start_i(start_i),
    .tgt_i(tgt_i), .token_i(token_i), .lc_escalate_en_i(esc), .owner_o(owner_o),
    .trans_req_o(trans_req_o), .trans_tgt_o(trans_tgt_o), .trans_token_o(trans_token_o),
    .trans_ack_i(trans_ack_i), .trans_err_i(trans_err_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .timeout_o(timeout_o), .locked_o(locked_o));

  lc_ctrl_xfer_arb #(.TargetWidth(TW), .TokenWidth(KW), .TimeoutCycles(TO), .TapPriority(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .claim_i(claim_i), .release_i(release_i), .start_i(start_i),
    .tgt_i(tgt_i), .token_i(token_i), .lc_escalate_en_i(esc), .owner_o(owner0),
    .trans_req_o(req0), .trans_tgt_o(tgt0), .trans_token_o(tok0),
    .trans_ack_i(trans_ack_i), .trans_err_i(trans_err_i), .busy_o(busy0), .done_o(done0),
    .err_o(err0), .timeout_o(tmo0), .locked_o(lck0));

  typedef struct {
    string         tag;
    logic [1:0]    owner;
    logic          req, busy, done, err, tmo, lck;
    logic [TW-1:0] tgt;
    logic [KW-1:0] tok;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clr_e();
    e.owner = '0; e.req = 0; e.busy = 0; e.done = 0; e.err = 0; e.tmo = 0; e.lck = 0;
    e.tgt = '0; e.tok = '0;
  endtask

  // Queue the expectation, advance one edge, then pop and compare; pulses drop afterwards.
  task automatic cyc(input string tag);
    exp_t x;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    claim_i = '0; release_i = '0; start_i = '0; trans_ack_i = 0; trans_err_i = 0;
    x = exp_q.pop_front();
    check({x.tag, ".owner"}, owner_o, x.owner);
    check({x.tag, ".req"}, trans_req_o, x.req);
    check({x.tag, ".busy"}, busy_o, x.busy);
    check({x.tag, ".done"}, done_o, x.done);
    check({x.tag, ".err"}, err_o, x.err);
    check({x.tag, ".timeout"}, timeout_o, x.tmo);
    check({x.tag, ".locked"}, locked_o, x.lck);
    check({x.tag, ".tgt"}, trans_tgt_o, x.tgt);
    check({x.tag, ".token"}, trans_token_o, x.tok);
    e.done = 0;
  endtask

  initial begin
    rst_ni = 0; claim_i = '0; release_i = '0; start_i = '0;
    tgt_i = '0; token_i = '0; esc = Off; trans_ack_i = 0; trans_err_i = 0;
    clr_e();
    cyc("reset");
    check("reset.owner_sw_prio", owner0, 2'b00);
    cyc("reset_hold");
    rst_ni = 1;

    claim_i = 2'b01; e.owner = 2'b01; cyc("sw_claim");
    cyc("own_hold");
    claim_i = 2'b10; cyc("tap_claim_ignored");
    start_i = 2'b10; release_i = 2'b10; cyc("nonowner_ignored");

    tgt_i[0] = 5'h0B; token_i[0] = {16{8'hA5}};
    tgt_i[1] = 5'h1F; token_i[1] = {16{8'h3C}};
    start_i = 2'b01; e.req = 1; e.busy = 1; e.tgt = 5'h0B; e.tok = {16{8'hA5}};
    cyc("start");
    tgt_i[0] = 5'h11; token_i[0] = {16{8'h5A}}; release_i = 2'b01;
    cyc("req_stable1");
    cyc("req_stable2");
    trans_ack_i = 1; e.req = 0; e.busy = 0; e.done = 1; cyc("ack");
    cyc("done_once");
    trans_ack_i = 1; cyc("ack_outside_req");

    start_i = 2'b01; e.req = 1; e.busy = 1; e.tgt = 5'h11; e.tok = {16{8'h5A}};
    cyc("start2");
    trans_ack_i = 1; trans_err_i = 1; e.req = 0; e.busy = 0; e.done = 1; e.err = 1;
    cyc("ack_err");
    cyc("err_sticky");
    start_i = 2'b01; e.req = 1; e.busy = 1; e.err = 0; cyc("start_clears_err");
    trans_ack_i = 1; e.req = 0; e.busy = 0; e.done = 1; cyc("ack_ok");
    release_i = 2'b01; start_i = 2'b01; clr_e(); cyc("release_wins");
    start_i = 2'b01; release_i = 2'b01; cyc("free_ignores");

    claim_i = 2'b11; e.owner = 2'b10; cyc("both_claim");
    check("both_claim.owner_sw_prio", owner0, 2'b01);

    start_i = 2'b10; e.req = 1; e.busy = 1; e.tgt = 5'h1F; e.tok = {16{8'h3C}};
    cyc("tmo_start");
    for (int i = 1; i < TO; i++) cyc("tmo_wait");
    e.req = 0; e.busy = 0; e.err = 1; e.tmo = 1; cyc("tmo_fire");
    cyc("tmo_sticky");

    start_i = 2'b10; e.req = 1; e.busy = 1; e.err = 0; e.tmo = 0; cyc("race_start");
    for (int i = 1; i < TO; i++) cyc("race_wait");
    trans_ack_i = 1; e.req = 0; e.busy = 0; e.done = 1; cyc("race_ack_wins");

    start_i = 2'b10; e.req = 1; e.busy = 1; cyc("esc_start");
    esc = On; e.owner = '0; e.req = 0; e.busy = 0; e.tgt = '0; e.tok = '0; e.lck = 1;
    cyc("esc_lock");
    esc = Off; claim_i = 2'b01; trans_ack_i = 1; cyc("lock_claim_ignored");
    start_i = 2'b01; release_i = 2'b11; cyc("lock_hold");
    rst_ni = 0; clr_e(); cyc("rst_unlock");
    rst_ni = 1;

    claim_i = 2'b01; e.owner = 2'b01; cyc("claim_after_rst");
    start_i = 2'b01; e.req = 1; e.busy = 1; e.tgt = 5'h11; e.tok = {16{8'h5A}};
    cyc("start_mid");
    rst_ni = 0; clr_e(); cyc("rst_mid_req");
    rst_ni = 1;
    claim_i = 2'b10; e.owner = 2'b10; cyc("tap_claim");
    esc = lc_tx_t'(4'b0000); e.owner = '0; e.lck = 1; cyc("esc_invalid_enc");
    esc = Off; rst_ni = 0; clr_e(); cyc("final_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lc_ctrl_xfer_arb.md
Name: lc_ctrl_xfer_arb

Overview:
- Arbitrates the life cycle transition interface between two requesters: software (CSR, index 0) and the JTAG TAP (index 1).
- Grants exclusive ownership through a claim/release mutex.
- Sequences a single transition request/acknowledge handshake to the main lc_ctrl FSM, with a timeout.
- Sits between the CSR/TAP register front-ends and the lc_ctrl FSM. Locks down permanently once escalation is broadcast.

Parameters:
- TargetWidth, 5: width of the decoded target life cycle state.
- TokenWidth, 128: width of the transition token.
- TimeoutCycles, 1024: number of cycles in Req without an ack before the request is aborted. Must be >= 2.
- TapPriority, 1'b1: on simultaneous claims, 1 = TAP wins, 0 = SW wins.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- claim_i  in  2  per-requester claim pulse/level
- release_i  in  2  per-requester release
- start_i  in  2  per-requester transition start
- tgt_i  in  2xTargetWidth  per-requester target state
- token_i  in  2xTokenWidth  per-requester token
- lc_escalate_en_i  in  lc_tx_t  escalation broadcast
- owner_o  out  2  one-hot current owner; 0 = free
- trans_req_o  out  1  request to FSM
- trans_tgt_o  out  TargetWidth  registered target
- trans_token_o  out  TokenWidth  registered token
- trans_ack_i  in  1  FSM completion
- trans_err_i  in  1  FSM error, qualified by ack
- busy_o  out  1  request outstanding
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error
- timeout_o  out  1  sticky timeout
- locked_o  out  1  escalation lockdown

Behaviour:
- Reset values: all outputs 0 (owner_o, trans_req_o, trans_tgt_o, trans_token_o, busy_o, done_o, err_o, timeout_o, locked_o). State = Free.
- Escalation: lc_escalate_en_i != Off (any non-Off encoding) counts as active.
- States:
  - Free: no owner.
    - Claim by one requester -> Owned; owner_o is that bit at the next cycle.
    - Both requesters claim -> the TapPriority winner is granted.
    - start_i and release_i are ignored.
  - Owned:
    - Claims, and starts/releases from the non-owner, are ignored.
    - A claim by the current owner is a no-op.
    - Owner release -> Free next cycle; owner_o, trans_tgt_o, trans_token_o, err_o and timeout_o are cleared.
    - Owner start -> Req next cycle; tgt_i/token_i of the owner are registered and trans_req_o=1; err_o and timeout_o are cleared.
    - Release and start in the same cycle: release wins and the start is dropped.
  - Req: trans_req_o=1, busy_o=1. The timeout counter runs from 0.
    - trans_ack_i=1 -> Owned; trans_req_o=0 and done_o=1 in the next cycle. err_o is set if trans_err_i=1.
    - Counter reaches TimeoutCycles-1 without ack -> Owned; trans_req_o=0, err_o=1, timeout_o=1, no done pulse.
    - Ack and timeout in the same cycle: ack wins.
    - Owner release and start are ignored in Req (release is not remembered).
    - trans_tgt_o and trans_token_o stay stable for the whole of Req.
  - Locked: entered from any state on the cycle after escalation is seen.
    - owner_o=0, trans_req_o=0, tgt/token zeroed, busy_o=0, locked_o=1.
    - Terminal until reset; ignores all inputs, including ack.
- Latency: claim -> owner_o in 1 cycle; start -> trans_req_o in 1 cycle; ack -> done_o in 1 cycle.
- trans_ack_i outside Req is ignored.
- Reset asserted mid-Req: synchronous return to reset values on the next clock edge; the token is cleared.
- Counter width is $clog2(TimeoutCycles). The counter saturates and never wraps; it clears on entry to Req.
- Illegal state encoding -> Locked.

Decomposition:
- lc_ctrl_pkg gains:
  - lc_xfer_st_e (Free, Owned, Req, Locked), sparse encoded with a Hamming distance >= 3.
  - lc_xfer_req_e (XferSw=0, XferTap=1).
  - lc_token_t.
- Sub-module lc_ctrl_xfer_timer: clear/enable saturating counter with an expired output.

Test Plan:
- SW claim cycle 0 -> owner_o=2'b01 at cycle 1; a TAP claim at cycle 3 is ignored and owner_o stays 2'b01.
- Simultaneous claim, TapPriority=1 -> owner_o=2'b10. Repeat with TapPriority=0 -> owner_o=2'b01.
- Owner start with tgt=5'h0B and token=128'hA5..A5 -> trans_req_o=1 one cycle later with matching outputs. ack three cycles later -> done_o pulses once and err_o=0.
- ack with trans_err_i=1 -> err_o=1 sticky. A new start clears it. Release -> all outputs 0.
- No ack, TimeoutCycles=16 -> trans_req_o drops exactly 16 cycles after rising; err_o=timeout_o=1; done_o never pulses. Ack and expiry in the same cycle -> done_o=1, timeout_o=0.
- lc_escalate_en_i=On while in Req -> next cycle trans_req_o=0, owner_o=0, token=0, locked_o=1; later claims are ignored until rst_ni=0.
